// File: rtl/mem_access_unit.sv
// Byte-serial data-memory initiator: splits 16-bit and byte load/store requests into little-endian byte cycles.
// Optional macro MISALIGN_TRAP_EN: odd-address word accesses complete immediately with err=1 and no memory cycles.
module mem_access_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        RESP
    } state_t;

    state_t            state;
    logic              op_write;
    logic              op_byte;
    logic              op_trap;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;
    logic [DATA_W-1:0] rdata;
    logic              misaligned;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ~req_byte & req_addr[0];
`else
    assign misaligned = 1'b0;
`endif

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // NOTE: every register here is state, so all use <= to sample pre-edge values consistently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            op_write   <= 1'b0;
            op_byte    <= 1'b0;
            op_trap    <= 1'b0;
            op_addr    <= '0;
            op_wdata   <= '0;
            rdata      <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            err        <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_write <= req_write;
                        op_byte  <= req_byte;
                        op_addr  <= req_addr;
                        op_wdata <= req_wdata;
                        rdata    <= '0;
                        if (misaligned) begin
                            // Trapped access skips the memory entirely.
                            op_trap <= 1'b1;
                            state   <= RESP;
                        end else begin
                            op_trap   <= 1'b0;
                            mem_addr  <= req_addr;
                            mem_wdata <= req_wdata[7:0];
                            mem_we    <= req_write;
                            state     <= LO;
                        end
                    end
                end
                LO: begin
                    if (!op_write) begin
                        rdata[7:0] <= mem_rdata;
                    end
                    if (op_byte) begin
                        mem_we <= 1'b0;
                        state  <= RESP;
                    end else begin
                        mem_addr  <= op_addr + ADDR_W'(1);
                        mem_wdata <= op_wdata[15:8];
                        mem_we    <= op_write;
                        state     <= HI;
                    end
                end
                HI: begin
                    if (!op_write) begin
                        rdata[15:8] <= mem_rdata;
                    end
                    mem_we <= 1'b0;
                    state  <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b1;
                    err        <= op_trap;
                    if (op_write || op_trap) begin
                        resp_rdata <= '0;
                    end else if (op_byte) begin
                        resp_rdata <= {8'h00, rdata[7:0]};
                    end else begin
                        resp_rdata <= rdata;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-array memory, directed plan cases, then random requests
// compared against a transaction-level reference of the memory contents.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        busy;
    logic        err;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic        bd_we;
    logic [15:0] bd_addr;
    logic [7:0]  bd_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_byte   (req_byte),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .busy       (busy),
        .err        (err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        @(posedge clk);
        #1;
        bd_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!req_ready && t < 10) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("ready_before_req", req_ready, 1);
    endtask

    // One complete transaction; expectations come from the byte-array reference only.
    task automatic run_req(input logic w, input logic b, input logic [15:0] a, input logic [15:0] wd);
        logic        trap;
        logic [15:0] a1;
        logic [15:0] exp_rdata;
        logic        we_seen;
        logic        hs_bad;
        int          exp_lat;
        int          lat;
        a1   = a + 16'd1;
        trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap = !b && a[0];
`endif
        exp_lat = trap ? 1 : (b ? 2 : 3);
        if (w || trap)  exp_rdata = 16'h0000;
        else if (b)     exp_rdata = {8'h00, ref_mem[a]};
        else            exp_rdata = {ref_mem[a1], ref_mem[a]};

        wait_ready();
        req_valid = 1'b1;
        req_write = w;
        req_byte  = b;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_byte  = 1'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);

        we_seen = mem_we;
        hs_bad  = req_ready | ~busy;
        if (!trap) check("lo_addr", mem_addr, a);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (resp_valid) begin
                lat = k;
                break;
            end
            we_seen = we_seen | mem_we;
            hs_bad  = hs_bad | req_ready | ~busy;
            if (k == 1 && !b && !trap) check("hi_addr", mem_addr, a1);
        end
        check("latency", lat, exp_lat);
        check("resp_rdata", resp_rdata, exp_rdata);
        check("err", err, trap);
        check("resp_idle_hs", {req_ready, busy}, 2'b10);
        check("mem_we_activity", we_seen, w && !trap);
        check("busy_handshake", hs_bad, 0);

        @(posedge clk);
        #1;
        check("resp_pulse", {resp_valid, err}, 2'b00);
        check("rdata_hold", resp_rdata, exp_rdata);

        if (w && !trap) begin
            ref_mem[a] = wd[7:0];
            if (!b) ref_mem[a1] = wd[15:8];
        end
        check("mem_lo", mem[a], ref_mem[a]);
        check("mem_hi", mem[a1], ref_mem[a1]);
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_byte  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        bd_we     = 1'b0;
        bd_addr   = '0;
        bd_data   = '0;

        #12;
        check("reset_outputs", {mem_we, mem_addr, mem_wdata, resp_valid, resp_rdata, err}, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_ready_busy", {req_ready, busy}, 2'b10);

        for (int i = 0; i < 256; i++) poke(16'hFF80 + 16'(i), 8'($urandom));

        // Directed cases.
        poke(16'h0000, 8'h56);
        poke(16'h0001, 8'h38);
        run_req(1'b0, 1'b0, 16'h0000, 16'h0000);
        check("word_load_value", resp_rdata, 16'h3856);
        poke(16'h0004, 8'h12);
        poke(16'h0005, 8'h43);
        run_req(1'b0, 1'b1, 16'h0004, 16'h0000);
        check("byte_load_value", resp_rdata, 16'h0012);
        run_req(1'b1, 1'b0, 16'h0010, 16'hBEEF);
        run_req(1'b0, 1'b0, 16'h0010, 16'h0000);
        check("store_load_back", resp_rdata, 16'hBEEF);
        poke(16'hFFFF, 8'hAD);
        poke(16'h0000, 8'hEF);
        run_req(1'b0, 1'b0, 16'hFFFF, 16'h0000);

        // Reset during the HI cycle of a word store.
        poke(16'h0021, 8'h5A);
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_byte  = 1'b0;
        req_addr  = 16'h0020;
        req_wdata = 16'h1234;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_hi_we", mem_we, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_we_async", mem_we, 0);
        ref_mem[16'h0020] = 8'h34;
        @(posedge clk);
        #1;
        check("rst_no_resp", resp_valid, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release", {req_ready, busy, resp_valid}, 3'b100);
        check("rst_mem_lo", mem[16'h0020], 8'h34);
        check("rst_mem_hi", mem[16'h0021], 8'h5A);

        // Held req_valid with the next request queued behind a byte store.
        poke(16'h0031, 8'h77);
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_byte  = 1'b1;
        req_addr  = 16'h0030;
        req_wdata = 16'h55AB;
        @(posedge clk);
        #1;
        req_write = 1'b0;
        check("b2b_lo_ready", req_ready, 0);
        @(posedge clk);
        #1;
        check("b2b_resp_ready", {req_ready, mem_we}, 2'b00);
        @(posedge clk);
        #1;
        check("b2b_idle", {req_ready, resp_valid}, 2'b11);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("b2b_accepted", {busy, mem_addr, mem_we}, {1'b1, 16'h0030, 1'b0});
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("b2b_second_resp", {resp_valid, resp_rdata}, {1'b1, 16'h00AB});
        ref_mem[16'h0030] = 8'hAB;
        check("b2b_mem_30", mem[16'h0030], ref_mem[16'h0030]);
        check("b2b_mem_31", mem[16'h0031], ref_mem[16'h0031]);

        // Randomized traffic inside the preloaded window, which straddles the FFFF->0000 wrap.
        for (int n = 0; n < 60; n++) begin
            logic        w;
            logic        b;
            logic [15:0] a;
            w = 1'($urandom);
            b = 1'($urandom);
            a = 16'hFF80 + 16'($urandom_range(0, 254));
            run_req(w, b, a, 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Pipeline-side initiator for the byte-addressed data memory. Accepts 16-bit load/store and byte load/store requests from the MEM stage over a valid/ready handshake. Sequences each request into one or two byte-wide memory cycles, little-endian: low byte at addr, high byte at addr+1. Returns load data zero-extended for byte loads and stalls the pipeline while busy.

Parameters:
ADDR_W, 16, byte address width; increments wrap modulo 2^ADDR_W
DATA_W, 16, pipeline data width; fixed at 2 bytes

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request this cycle
req_write  in  1  1 = store, 0 = load
req_byte  in  1  1 = byte access (lbu/sb), 0 = 16-bit word access
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data; bits [7:0] only for byte stores
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  load result; 0 for stores
busy  out  1  request in flight; pipeline stall
err  out  1  misaligned-access flag; see Optional Feature
mem_addr  out  ADDR_W  byte address to data memory
mem_wdata  out  8  byte write data
mem_we  out  1  byte write enable
mem_rdata  in  8  byte read data; combinational from mem_addr

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - resp_valid=0, resp_rdata=0, err=0.
  - Internal data registers cleared.
  - req_ready=1 and busy=0 after reset_n deasserts.
- Reset mid-operation aborts immediately:
  - mem_we drops asynchronously.
  - A word store reset after its LO cycle leaves only the low byte written.
  - No resp_valid is issued.
- Memory-port outputs are registered and change only on clk edges or reset.
- State machine: IDLE, LO, HI, RESP.
  - IDLE:
    - req_ready=1, busy=0.
    - On req_valid, capture write, byte, addr and wdata.
    - Load mem_addr=addr, mem_wdata=wdata[7:0], mem_we=write; go to LO.
  - LO:
    - Memory performs the low-byte access.
    - Loads: mem_rdata is sampled into rdata[7:0] at the clock edge.
    - If byte: mem_we<=0, go to RESP.
    - Else: mem_addr<=addr+1 (wraps FFFF->0000), mem_wdata<=wdata[15:8], mem_we<=write; go to HI.
  - HI:
    - Loads: sample mem_rdata into rdata[15:8].
    - mem_we<=0; go to RESP.
  - RESP:
    - resp_valid=1 for exactly one cycle.
    - resp_rdata = {8'h00, rdata[7:0]} for byte loads, {rdata[15:8], rdata[7:0]} for word loads, 0 for stores.
    - Go to IDLE.
- Only busy tracks the handshake state. resp_rdata holds its value until the next RESP; resp_valid and err are pulses.
- busy=1 in LO/HI/RESP. req_ready=0 outside IDLE, and requests are ignored there.
- Latency from the accept edge to resp_valid high:
  - byte access: 2 cycles
  - word access: 3 cycles
- Back-to-back requests: the next request can be accepted in the cycle after RESP. Throughput is 1 request per 3 (byte) or 4 (word) cycles.
- mem_we is never high in IDLE or RESP.
- Loads never assert mem_we.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a word access (req_byte=0) with req_addr[0]=1 is accepted but issues no memory cycles. It goes IDLE->RESP with resp_valid=1, err=1 for that one cycle and resp_rdata=0. Memory is never written.
- Undefined: misaligned word accesses proceed normally, including FFFF->0000 wrap. err is tied to 0.

Test Plan:
- Memory preloaded 0000:56, 0001:38; word load addr 0x0000 -> resp_valid 3 cycles after accept, resp_rdata=0x3856, mem_we never high.
- Memory 0004:12, 0005:43; byte load addr 0x0004 -> resp_valid 2 cycles after accept, resp_rdata=0x0012.
- Word store 0xBEEF to 0x0010, then word load 0x0010 -> mem[0010]=EF, mem[0011]=BE; load returns 0xBEEF; store resp_rdata=0.
- Memory FFFF:AD, 0000:EF; word load 0xFFFF:
  - macro undefined -> HI cycle mem_addr=0x0000, resp_rdata=0xEFAD;
  - macro defined -> err=1, resp_rdata=0, no memory cycles.
- Word store 0x1234 to 0x0020 with reset_n pulsed low during HI -> mem_we falls immediately, mem[0020]=34, mem[0021] unchanged, no resp_valid, req_ready=1 after release.
- Byte store 0xAB to 0x0030 with req_valid held high and the next request queued -> req_ready=0 in LO/RESP; second request accepted in the cycle after RESP; mem[0031] untouched.
